deserializer: RTL and testbench
===============================

# deserializer

Collects a stream of WORD_WIDTH-bit words into one FRAME_WIDTH-bit frame, the receive-side counterpart of the serializer. With defaults it gathers 16 words of 16 bits into a 256-bit frame, the parallel input of the 8-point FFT core (8 complex samples, 16-bit real and 16-bit imaginary). It sits between the serial link and the FFT input register. It buffers one complete frame, so word reception continues while the downstream stage is busy.

## Interface
- FRAME_WIDTH, 256, width of the assembled frame; must be an integer multiple of WORD_WIDTH
- WORD_WIDTH, 16, width of one serial word
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of the partially assembled frame
- input_valid  input  1  input_data carries a word
- input_ready  output  1  deserializer can accept a word this cycle
- input_data  input  WORD_WIDTH  serial word
- output_valid  output  1  output_data holds a complete frame
- output_ready  input  1  downstream consumes the frame this cycle
- output_data  output  FRAME_WIDTH  assembled frame
- word_count  output  $clog2(NUM_WORDS)  number of words in the partial frame
- deserialization_done  output  1  one-cycle pulse on the cycle after the last word of a frame is accepted

## Operation
- NUM_WORDS = FRAME_WIDTH/WORD_WIDTH (16 with the defaults).
- Word accept: input_valid && input_ready at a rising edge.
- Word ordering matches the serializer. The first word of a frame lands in output_data[FRAME_WIDTH-1 -: WORD_WIDTH] (MSW). The last word lands in bits [WORD_WIDTH-1:0].
- Assembly register: a shift-left-by-WORD_WIDTH register. The new word enters the low bits. word_count increments on each accept.
- On acceptance of word NUM_WORDS-1:
  - the assembled value, including the word arriving on that edge, is copied into the output register;
  - output_valid is set, word_count wraps to 0 and deserialization_done pulses.
- The output register holds its value and output_valid stays high until output_valid && output_ready. On that edge output_valid clears, unless a new frame completes on the same edge, in which case it stays high with the new data.
- input_ready = !(word_count == NUM_WORDS-1 && output_valid && !output_ready). This is combinational from output_ready by design.
  - Only the frame-completing word is stalled. Words 0..NUM_WORDS-2 are always accepted.
- flush:
  - clears word_count and the assembly register;
  - leaves the output register and output_valid untouched;
  - takes priority over a simultaneous word accept, and the word is dropped.
- reset has priority over everything. After reset:
  - output_valid = 0, output_data = 0, word_count = 0, deserialization_done = 0;
  - input_ready = 1.
- Reset or flush mid-frame discards the partial frame. No error is flagged.
- Holes in input_valid are allowed at any position. Only accepted words count.

## Timing
- Latency: output_valid and the new output_data are visible from the edge that accepts the last word. The first cycle a consumer can see the frame is the cycle after that edge.
- Throughput: one word per cycle sustained. Back-to-back frames need no idle cycle when output_ready is high at each frame completion.
- deserialization_done is high for exactly the one cycle after each completing edge. It is independent of output_ready.
- output_data is stable while output_valid && !output_ready.
- The word that stalls because of a full output register is accepted on the first cycle that output_ready is high (or output_valid is low). The frame is then replaced in the same edge.

## Structure
- Shared package fft_pkg holds:
  - the default FRAME_WIDTH, WORD_WIDTH and NUM_WORDS constants;
  - the SAMPLE_WIDTH constant (16) used for the frame ↔ complex-sample mapping.
- Single module with no sub-module. It contains the counter, the assembly shift register, the output register and the valid flag.

## Test plan
- Reset then 16 consecutive words 0x0123, 0x4567, 0x89AB, 0xCDEF (repeated ×4), output_ready=1.
  - Required: output_data = 256'h0123456789ABCDEF repeated ×4.
  - output_valid and deserialization_done high for 1 cycle; word_count returns to 0.
- Second frame FEDC, BA98, 7654, 3210 ×4 sent with random input_valid gaps.
  - Required: the exact frame, with the done pulse after the 16th accept only.
- Backpressure: output_ready=0 after frame 1 while frame 2 streams.
  - Required: words 0–14 are accepted and input_ready drops at word_count = 15.
  - Frame 1 data is held unchanged.
  - Raising output_ready for one cycle consumes frame 1 and loads frame 2 on the same edge, with output_valid staying high.
- flush after 7 words, then 16 new words.
  - Required: the output frame contains only the 16 new words and word_count goes 7 → 0.
  - A flush coinciding with an accept drops that word.
- Reset asserted mid-frame (word_count = 9) with a completed frame pending.
  - Required: the next edge gives output_valid = 0, output_data = 0, word_count = 0, input_ready = 1.
- Two frames streamed with no idle cycle and output_ready = 1.
  - Required: two done pulses exactly 16 cycles apart and both frames correct.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT frame/word constants used by the serial link blocks
package fft_pkg;

  localparam int DEF_FRAME_WIDTH = 256;
  localparam int DEF_WORD_WIDTH  = 16;
  localparam int DEF_NUM_WORDS   = DEF_FRAME_WIDTH / DEF_WORD_WIDTH;
  localparam int SAMPLE_WIDTH    = 16;

  // Complex sample idx sits at the MSB end for idx 0; real half above imaginary half.
  function automatic logic [SAMPLE_WIDTH-1:0] sample_re(
    input logic [DEF_FRAME_WIDTH-1:0] frame,
    input int                         idx
  );
    return frame[DEF_FRAME_WIDTH-1-2*SAMPLE_WIDTH*idx -: SAMPLE_WIDTH];
  endfunction

  function automatic logic [SAMPLE_WIDTH-1:0] sample_im(
    input logic [DEF_FRAME_WIDTH-1:0] frame,
    input int                         idx
  );
    return frame[DEF_FRAME_WIDTH-1-SAMPLE_WIDTH-2*SAMPLE_WIDTH*idx -: SAMPLE_WIDTH];
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// rtl/deserializer_if.sv - word input and frame output handshake bundle of the deserializer
interface deserializer_if
  import fft_pkg::*;
#(
  parameter int FRAME_WIDTH = DEF_FRAME_WIDTH,
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH
);

  logic                   input_valid;
  logic                   input_ready;
  logic [WORD_WIDTH-1:0]  input_data;
  logic                   output_valid;
  logic                   output_ready;
  logic [FRAME_WIDTH-1:0] output_data;

  modport master (
    output input_valid,
    output input_data,
    output output_ready,
    input  input_ready,
    input  output_valid,
    input  output_data
  );

  modport slave (
    input  input_valid,
    input  input_data,
    input  output_ready,
    output input_ready,
    output output_valid,
    output output_data
  );

endinterface

// File: rtl/deserializer.sv
// rtl/deserializer.sv - gathers NUM_WORDS serial words into one frame with a one-frame output buffer
module deserializer
  import fft_pkg::*;
#(
  parameter int FRAME_WIDTH = DEF_FRAME_WIDTH,
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       flush,
  deserializer_if.slave                              bus,
  output logic [$clog2(FRAME_WIDTH/WORD_WIDTH)-1:0]  word_count,
  output logic                                       deserialization_done
);

  localparam int NUM_WORDS = FRAME_WIDTH / WORD_WIDTH;
  localparam int CW        = $clog2(NUM_WORDS);
  localparam int ASM_W     = FRAME_WIDTH - WORD_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  logic [CW-1:0]          count_q, count_d;
  logic [ASM_W-1:0]       asm_q, asm_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  logic                   last_word;
  logic                   in_ready;
  logic                   accept;
  logic                   complete;
  logic [FRAME_WIDTH-1:0] shifted;

  // Only the frame-completing word waits for room in the output register.
  assign last_word = (count_q == LAST_IDX);
  assign in_ready  = !(last_word && valid_q && !bus.output_ready);
  assign accept    = bus.input_valid && in_ready;
  assign complete  = accept && last_word && !flush;
  assign shifted   = {asm_q, bus.input_data};

  always_comb begin
    count_d = count_q;
    asm_d   = asm_q;
    frame_d = frame_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if (flush) begin
      count_d = '0;
      asm_d   = '0;
    end else if (accept) begin
      count_d = last_word ? '0 : count_q + CW'(1);
      asm_d   = shifted[ASM_W-1:0];
    end

    // A completing frame overrides the consume so output_valid stays high.
    if (complete) begin
      frame_d = shifted;
      valid_d = 1'b1;
      done_d  = 1'b1;
    end else if (valid_q && bus.output_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      asm_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      asm_q   <= asm_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.input_ready   = in_ready;
  assign bus.output_valid  = valid_q;
  assign bus.output_data   = frame_q;
  assign word_count           = count_q;
  assign deserialization_done = done_q;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed vector bench for the deserializer
module tb_deserializer;
  import fft_pkg::*;

  localparam int FW = DEF_FRAME_WIDTH;
  localparam int WW = DEF_WORD_WIDTH;
  localparam int NW = DEF_NUM_WORDS;
  localparam int CW = $clog2(NW);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] word_count;
  logic          deserialization_done;

  deserializer_if #(.FRAME_WIDTH(FW), .WORD_WIDTH(WW)) bus ();

  deserializer #(.FRAME_WIDTH(FW), .WORD_WIDTH(WW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .flush                (flush),
    .bus                  (bus),
    .word_count           (word_count),
    .deserialization_done (deserialization_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          flush;
    logic          valid;
    logic [WW-1:0] data;
    logic          oready;
    logic          exp_ready;
    logic [CW-1:0] exp_count;
    logic          exp_valid;
    logic          exp_done;
  } vec_t;

  int tests = 0;
  int fails = 0;

  localparam logic [FW-1:0] F1 = {4{64'h0123456789ABCDEF}};
  localparam logic [FW-1:0] F2 = {4{64'hFEDCBA9876543210}};

  logic [WW-1:0] f1w [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
  logic [WW-1:0] f2w [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic [WW-1:0] d, input logic r);
    flush            = f;
    bus.input_valid  = v;
    bus.input_data   = d;
    bus.output_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t x, input string tag);
    drive(x.flush, x.valid, x.data, x.oready);
    chk({tag, "_ready"}, bus.input_ready, x.exp_ready);
    tick();
    chk({tag, "_count"}, word_count, x.exp_count);
    chk({tag, "_valid"}, bus.output_valid, x.exp_valid);
    chk({tag, "_done"}, deserialization_done, x.exp_done);
  endtask

  vec_t          vecs[$];
  logic [FW-1:0] exp3, exp4, expx;
  int            pulses[$];
  int            ngap;

  initial begin
    // Frame 1 table: 16 back-to-back words, then one idle cycle that consumes the frame.
    for (int i = 0; i < NW; i++)
      vecs.push_back('{1'b0, 1'b1, f1w[i%4], 1'b1, 1'b1, CW'((i+1) % NW), i == NW-1, i == NW-1});
    vecs.push_back('{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, CW'(0), 1'b0, 1'b0});

    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();
    chk("rst_valid", bus.output_valid, 0);
    chk("rst_data", bus.output_data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_done", deserialization_done, 0);
    chk("rst_ready", bus.input_ready, 1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], $sformatf("f1_v%0d", i));
      if (i == NW-1) chk("f1_data", bus.output_data, F1);
    end

    // Frame 2 with idle gaps between accepted words.
    for (int w = 0; w < NW; w++) begin
      ngap = $urandom_range(0, 2);
      for (int g = 0; g < ngap; g++) begin
        drive(1'b0, 1'b0, 16'hFFFF, 1'b1);
        tick();
        chk("f2_gap_done", deserialization_done, 0);
        chk("f2_gap_count", word_count, w);
      end
      drive(1'b0, 1'b1, f2w[w%4], 1'b1);
      tick();
      chk("f2_count", word_count, (w+1) % NW);
      chk("f2_done", deserialization_done, w == NW-1);
    end
    chk("f2_valid", bus.output_valid, 1);
    chk("f2_data", bus.output_data, F2);

    // Backpressure: frame 2 stays pending while frame 3 streams.
    exp3 = '0;
    for (int w = 0; w < NW; w++) exp3 = {exp3[FW-WW-1:0], WW'(16'h3000 + w)};
    for (int w = 0; w < NW-1; w++) begin
      drive(1'b0, 1'b1, WW'(16'h3000 + w), 1'b0);
      chk("bp_ready", bus.input_ready, 1);
      tick();
      chk("bp_count", word_count, w + 1);
      chk("bp_hold", bus.output_data, F2);
    end
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 1'b1, 16'h300F, 1'b0);
      chk("bp_stall_ready", bus.input_ready, 0);
      tick();
      chk("bp_stall_count", word_count, NW-1);
      chk("bp_stall_valid", bus.output_valid, 1);
      chk("bp_stall_data", bus.output_data, F2);
      chk("bp_stall_done", deserialization_done, 0);
    end
    drive(1'b0, 1'b1, 16'h300F, 1'b1);
    chk("bp_release_ready", bus.input_ready, 1);
    tick();
    chk("bp_swap_valid", bus.output_valid, 1);
    chk("bp_swap_data", bus.output_data, exp3);
    chk("bp_swap_done", deserialization_done, 1);
    chk("bp_swap_count", word_count, 0);

    // Flush after 7 words with frame 3 pending; the word on the flush edge is dropped.
    for (int w = 0; w < 7; w++) begin
      drive(1'b0, 1'b1, WW'(16'hA000 + w), 1'b0);
      tick();
    end
    chk("fl_count7", word_count, 7);
    drive(1'b1, 1'b1, 16'hDEAD, 1'b0);
    tick();
    chk("fl_count0", word_count, 0);
    chk("fl_keep_valid", bus.output_valid, 1);
    chk("fl_keep_data", bus.output_data, exp3);
    chk("fl_done", deserialization_done, 0);
    exp4 = '0;
    for (int w = 0; w < NW; w++) begin
      exp4 = {exp4[FW-WW-1:0], WW'(16'h5000 + w)};
      drive(1'b0, 1'b1, WW'(16'h5000 + w), 1'b1);
      tick();
      chk("fl_new_count", word_count, (w+1) % NW);
    end
    chk("fl_new_data", bus.output_data, exp4);
    chk("fl_new_done", deserialization_done, 1);

    // Reset at word_count 9 with frame 4 still pending.
    for (int w = 0; w < 9; w++) begin
      drive(1'b0, 1'b1, WW'(16'h6000 + w), 1'b0);
      tick();
    end
    chk("mr_count9", word_count, 9);
    chk("mr_pending", bus.output_valid, 1);
    reset = 1'b1;
    drive(1'b0, 1'b1, 16'h7777, 1'b0);
    tick();
    chk("mr_valid", bus.output_valid, 0);
    chk("mr_data", bus.output_data, 0);
    chk("mr_count", word_count, 0);
    chk("mr_done", deserialization_done, 0);
    chk("mr_ready", bus.input_ready, 1);
    reset = 1'b0;

    // Two frames back-to-back with no idle cycle.
    for (int w = 0; w < 2*NW; w++) begin
      drive(1'b0, 1'b1, (w < NW) ? f1w[w%4] : f2w[w%4], 1'b1);
      chk("bb_ready", bus.input_ready, 1);
      tick();
      if (deserialization_done) pulses.push_back(w);
      if (w == NW-1)   chk("bb_data_a", bus.output_data, F1);
      if (w == 2*NW-1) chk("bb_data_b", bus.output_data, F2);
    end
    chk("bb_pulses", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("bb_first", pulses[0], NW-1);
      chk("bb_spacing", pulses[1] - pulses[0], NW);
    end
    expx = bus.output_data;
    chk("bb_sample0_re", sample_re(expx, 0), 16'hFEDC);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    tick();
    chk("bb_consumed", bus.output_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
